// File: rtl/giraffe_pkg.sv
// giraffe_pkg: shared state encoding, host command codes and counter sizing for the capture sequencer
package giraffe_pkg;
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ADC_RST = 4'd1,
    CALIB   = 4'd2,
    CONV    = 4'd3,
    SEND    = 4'd4,
    TX_HOLD = 4'd5
  } state_t;
  localparam logic [7:0] CMD_CAPTURE = 8'hA5;
  localparam logic [7:0] CMD_CALIB = 8'h5A;
  localparam logic [7:0] CMD_ABORT = 8'hFF;
  localparam int NUM_SAMPLED_DEF = 102400;
  localparam int CNT_W = $clog2(NUM_SAMPLED_DEF + 1);
endpackage

// File: rtl/giraffe_ack_sync.sv
// giraffe_ack_sync: two-flop synchroniser for the ADC done pin plus rising-edge detect
module giraffe_ack_sync (
  input  logic clk,
  input  logic rst,
  input  logic ack,
  output logic rise
);
  logic [2:0] sr;
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else sr <= {sr[1:0], ack};
  assign rise = sr[1] & ~sr[2];
endmodule

// File: rtl/giraffe_capture_sequencer.sv
// giraffe_capture_sequencer: host-command driven reset/calibrate/capture sequencer for the Giraffe SAR ADC
module giraffe_capture_sequencer
  import giraffe_pkg::*;
#(
  parameter int N_bit       = 6,
  parameter int NUM_Sampled = NUM_SAMPLED_DEF,
  parameter int RST_CYCLES  = 64,
  parameter int CAL_CYCLES  = 4096,
  parameter int ACK_TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_vld,
  output logic [7:0]       tx_wdata,
  output logic             tx_wreq,
  input  logic             tx_rdy,
  output logic             rstn_adc,
  output logic             calib_ena_adc,
  output logic             adc_ena,
  input  logic             adc_ack,
  input  logic [N_bit-1:0] dout_adc,
  output logic             cap_rstn,
  output logic [17:0]      cnt_send,
  output logic [3:0]       state_o,
  output logic             busy,
  output logic             err_timeout
);
  localparam int TW = $clog2(ACK_TIMEOUT + RST_CYCLES + CAL_CYCLES + 1);
  state_t state;
  logic cmd_cal, ack_rise, abort, last;
  logic [TW-1:0] tmr;
  giraffe_ack_sync u_sync (.clk(clk), .rst(rst), .ack(adc_ack), .rise(ack_rise));
  assign abort = rx_vld && rx_data == CMD_ABORT && state != IDLE;
  assign last = cnt_send + 18'd1 == 18'(NUM_Sampled);
  assign state_o = state;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cmd_cal <= 1'b0;
      tmr <= '0;
      tx_wdata <= '0;
      tx_wreq <= 1'b0;
      rstn_adc <= 1'b0;
      calib_ena_adc <= 1'b0;
      adc_ena <= 1'b0;
      cap_rstn <= 1'b0;
      cnt_send <= '0;
      err_timeout <= 1'b0;
    end else begin
      tx_wreq <= 1'b0;
      // abort beats everything, but a write already granted by tx_rdy still goes out
      if (abort) begin
        state <= IDLE;
        adc_ena <= 1'b0;
        calib_ena_adc <= 1'b0;
        rstn_adc <= 1'b1;
        cap_rstn <= 1'b1;
        tx_wreq <= state == SEND && tx_rdy;
      end else begin
        case (state)
          IDLE: begin
            rstn_adc <= 1'b1;
            cap_rstn <= 1'b1;
            if (rx_vld && (rx_data == CMD_CAPTURE || rx_data == CMD_CALIB)) begin
              state <= ADC_RST;
              cmd_cal <= rx_data == CMD_CALIB;
              rstn_adc <= 1'b0;
              cap_rstn <= 1'b0;
              cnt_send <= '0;
              err_timeout <= 1'b0;
              tmr <= '0;
            end
          end
          ADC_RST:
            if (tmr == TW'(RST_CYCLES - 1)) begin
              rstn_adc <= 1'b1;
              cap_rstn <= 1'b1;
              tmr <= '0;
              state <= cmd_cal ? CALIB : CONV;
              calib_ena_adc <= cmd_cal;
              adc_ena <= !cmd_cal;
            end else tmr <= tmr + TW'(1);
          CALIB:
            if (tmr == TW'(CAL_CYCLES - 1)) begin
              calib_ena_adc <= 1'b0;
              state <= IDLE;
            end else tmr <= tmr + TW'(1);
          // ack is tested first so a simultaneous expiry still captures the sample
          CONV:
            if (ack_rise) begin
              tx_wdata <= 8'(dout_adc);
              adc_ena <= 1'b0;
              state <= SEND;
            end else if (tmr == TW'(ACK_TIMEOUT - 1)) begin
              err_timeout <= 1'b1;
              adc_ena <= 1'b0;
              state <= IDLE;
            end else tmr <= tmr + TW'(1);
          SEND:
            if (tx_rdy) begin
              tx_wreq <= 1'b1;
              tmr <= '0;
              state <= TX_HOLD;
            end
          // first cycle skipped: tx_rdy only falls the cycle after the write is accepted
          TX_HOLD:
            if (tmr == '0) tmr <= TW'(1);
            else if (tx_rdy) begin
              cnt_send <= &cnt_send ? cnt_send : cnt_send + 18'd1;
              tmr <= '0;
              state <= last ? IDLE : CONV;
              adc_ena <= !last;
            end
          default: state <= IDLE;
        endcase
      end
    end
endmodule
